// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one registered bitwise logic unit
// Optional: define LOGIC_UNIT_ARBITER_STATS_EN to add the stat_done_cnt completion counter.
module logic_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [3*NUM_REQ-1:0]       req_op,
    input  logic [DATA_W*NUM_REQ-1:0]  req_a,
    input  logic [DATA_W*NUM_REQ-1:0]  req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       rsp_err,
`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    output logic [15:0]                stat_done_cnt,
`endif
    output logic                       busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_last_grant;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [ID_W-1:0]     r_id;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_rsp_err;

    logic                w_any;
    logic [ID_W-1:0]     w_winner;
    logic [2:0]          w_win_op;
    logic [DATA_W-1:0]   w_win_a;
    logic [DATA_W-1:0]   w_win_b;
    logic [DATA_W-1:0]   w_result;
    logic                w_err;
    logic                w_rsp_fire;

    assign w_any      = |req_valid;
    assign w_rsp_fire = r_rsp_valid & rsp_ready;

    // Scan upward from the requester after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        int              v_idx;
        logic [ID_W-1:0] v_sel;
        logic            v_found;
        v_idx    = 0;
        v_sel    = '0;
        v_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = (int'(r_last_grant) + k) % NUM_REQ;
            v_sel = ID_W'(v_idx);
            if (!v_found && req_valid[v_sel]) begin
                v_found  = 1'b1;
                w_winner = v_sel;
            end
        end
    end

    always_comb begin
        w_win_op = '0;
        w_win_a  = '0;
        w_win_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_win_op = req_op[3*i +: 3];
                w_win_a  = req_a[DATA_W*i +: DATA_W];
                w_win_b  = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_op)
            3'd0:    w_result = ~r_a;
            3'd1:    w_result = r_a & r_b;
            3'd2:    w_result = ~(r_a & r_b);
            3'd3:    w_result = r_a | r_b;
            3'd4:    w_result = ~(r_a | r_b);
            3'd5:    w_result = r_a ^ r_b;
            3'd6:    w_result = ~(r_a ^ r_b);
            default: w_err    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (w_rsp_fire) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (r_state != S_IDLE);
        if (r_state == S_IDLE && w_any) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op         <= w_win_op;
                        r_a          <= w_win_a;
                        r_b          <= w_win_b;
                        r_id         <= w_winner;
                        r_last_grant <= w_winner;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_err   <= w_err;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (w_rsp_fire) r_rsp_valid <= 1'b0;
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;

`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    logic [15:0] r_stat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_cnt <= '0;
        end else if (w_rsp_fire && r_stat_cnt != 16'hFFFF) begin
            r_stat_cnt <= r_stat_cnt + 16'd1;
        end
    end

    assign stat_done_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [3*NUM_REQ-1:0]      req_op = '0;
    logic [DATA_W*NUM_REQ-1:0] req_a = '0;
    logic [DATA_W*NUM_REQ-1:0] req_b = '0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_err;
    logic                      busy;
`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    logic [15:0]               stat_done_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic_unit_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
`ifdef LOGIC_UNIT_ARBITER_STATS_EN
        .stat_done_cnt(stat_done_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ref_logic(input int op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        case (op)
            0: return ~a;
            1: return a & b;
            2: return ~(a & b);
            3: return a | b;
            4: return ~(a | b);
            5: return a ^ b;
            6: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic set_req(input int i, input int op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req_op[3*i +: 3]          = 3'(op);
        req_a[DATA_W*i +: DATA_W] = a;
        req_b[DATA_W*i +: DATA_W] = b;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h id=%0d err=%b busy=%b ready=%b, want all zero",
                     rsp_valid, rsp_data, rsp_id, rsp_err, busy, req_ready);
        end
`ifdef LOGIC_UNIT_ARBITER_STATS_EN
        checks++;
        if (stat_done_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stat: got %h want 0000", stat_done_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_op;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, 1, 8'hF0, 8'h3C);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        set_req(0, 0, 8'hFF, 8'hFF);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_exec: got valid=%b busy=%b want valid=0 busy=1", rsp_valid, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, 8'h30, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp: got valid=%b data=%h id=%0d err=%b want 1 30 0 0", rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_all_opcodes;
        logic [DATA_W-1:0] exp_tab [8];
        exp_tab = '{8'h5A, 8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'h00};
        rsp_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            @(negedge clk);
            set_req(2, op, 8'hA5, 8'h0F);
            req_valid = 4'b0100;
            #1;
            checks++;
            if (req_ready !== 4'b0100) begin
                errors++;
                $display("FAIL opc_ready op=%0d: got %b want 0100", op, req_ready);
            end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, exp_tab[op], 2'd2, (op == 7)}) begin
                errors++;
                $display("FAIL opc_rsp op=%0d: got valid=%b data=%h id=%0d err=%b want 1 %h 2 %b",
                         op, rsp_valid, rsp_data, rsp_id, rsp_err, exp_tab[op], (op == 7));
            end
        end
    endtask

    task automatic test_round_robin;
        logic [NUM_REQ-1:0] exp_ready;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3, 8'(i), 8'h10);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_ready = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_ready cyc=%0d: got %b want %b", c, req_ready, exp_ready);
            end
            if (c % 3 == 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((c / 3) % 4) || rsp_data !== (8'h10 | 8'((c / 3) % 4))) begin
                    errors++;
                    $display("FAIL rr_rsp cyc=%0d: got valid=%b id=%0d data=%h want 1 %0d %h",
                             c, rsp_valid, rsp_id, rsp_data, (c / 3) % 4, 8'h10 | 8'((c / 3) % 4));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        set_req(2, 5, 8'h3C, 8'hFF);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_grant: got %b want 0100", req_ready);
        end
        @(negedge clk);
        set_req(2, 1, 8'h00, 8'h00);
        for (int c = 2; c < 12; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_err, req_ready} !== {1'b1, 8'hC3, 2'd2, 1'b0, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d: got valid=%b data=%h id=%0d err=%b ready=%b want 1 c3 2 0 0000",
                         c, rsp_valid, rsp_data, rsp_id, rsp_err, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0 1000", rsp_valid, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid;
        set_req(0, 3, 8'h12, 8'h40);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            req_valid = 4'b1111;
            @(negedge clk);
            req_valid = '0;
            if (s == 1) @(negedge clk);
            #1;
            rst = 1'b1;
            #1;
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_err, busy, req_ready} !== '0) begin
                errors++;
                $display("FAIL midrst_%s: got valid=%b data=%h id=%0d err=%b busy=%b ready=%b want all zero",
                         (s == 0) ? "exec" : "resp", rsp_valid, rsp_data, rsp_id, rsp_err, busy, req_ready);
            end
            @(negedge clk);
            rst       = 1'b0;
            req_valid = 4'b1111;
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++;
                $display("FAIL midrst_prio s=%0d: got %b want 0001", s, req_ready);
            end
            req_valid = '0;
        end
        rsp_ready = 1'b1;
        do_reset();
    endtask

    task automatic test_random;
        int                 m_last;
        bit                 m_busy;
        int                 m_grant_cyc;
        logic [DATA_W-1:0]  m_data;
        int                 m_id;
        logic               m_err;
        int                 win;
        logic [NUM_REQ-1:0] exp_ready;
        bit                 exp_valid;
        do_reset();
        m_last = NUM_REQ - 1;
        m_busy = 0;
        m_grant_cyc = 0;
        m_data = '0;
        m_id = 0;
        m_err = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            win = -1;
            if (!m_busy) begin
                for (int k = 1; k <= NUM_REQ && win < 0; k++)
                    if (req_valid[(m_last + k) % NUM_REQ]) win = (m_last + k) % NUM_REQ;
            end
            exp_ready = (win >= 0) ? 4'(1 << win) : 4'b0000;
            exp_valid = m_busy && (cyc >= m_grant_cyc + 2);
            checks++;
            if (req_ready !== exp_ready || rsp_valid !== exp_valid || busy !== (m_busy && cyc > m_grant_cyc)) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d: got ready=%b valid=%b busy=%b want %b %b %b",
                         cyc, req_ready, rsp_valid, busy, exp_ready, exp_valid, (m_busy && cyc > m_grant_cyc));
            end
            if (exp_valid) begin
                checks++;
                if (rsp_data !== m_data || rsp_id !== 2'(m_id) || rsp_err !== m_err) begin
                    errors++;
                    $display("FAIL rand_rsp cyc=%0d: got data=%h id=%0d err=%b want %h %0d %b",
                             cyc, rsp_data, rsp_id, rsp_err, m_data, m_id, m_err);
                end
                if (rsp_ready) m_busy = 0;
            end
            if (win >= 0) begin
                m_busy      = 1;
                m_grant_cyc = cyc;
                m_last      = win;
                m_id        = win;
                m_data      = ref_logic(int'(req_op[3*win +: 3]), req_a[DATA_W*win +: DATA_W], req_b[DATA_W*win +: DATA_W]);
                m_err       = (req_op[3*win +: 3] == 3'd7);
            end
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    task automatic run_stat_ops(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            set_req(1, (j == 1) ? 7 : j, 8'h5A, 8'h33);
            req_valid = 4'b0010;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_stats;
        do_reset();
        rsp_ready = 1'b1;
        run_stat_ops(5);
        #1;
        checks++;
        if (stat_done_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stat_count: got %0d want 5", stat_done_cnt);
        end
        dut.r_stat_cnt = 16'hFFFE;
        run_stat_ops(3);
        #1;
        checks++;
        if (stat_done_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stat_saturate: got %h want ffff", stat_done_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_all_opcodes();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef LOGIC_UNIT_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered bitwise logic unit (NOT/AND/NAND/OR/NOR/XOR/XNOR) among NUM_REQ requesters.
- Arbitration is round-robin.
- Requests use a valid/ready handshake; each response is tagged with the winning requester's index and is held under backpressure.
- Sits between client blocks that need gate operations and the single shared logic datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width in bits.
- ID_W, 2, width of the requester index; must be at least ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  request valid, one bit per requester.
- req_ready  output  NUM_REQ  request accepted, one-hot, combinational.
- req_op  input  3*NUM_REQ  opcode per requester; requester i uses bits [3i+2:3i].
- req_a  input  DATA_W*NUM_REQ  operand A per requester; slice i.
- req_b  input  DATA_W*NUM_REQ  operand B per requester; slice i.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts response.
- rsp_data  output  DATA_W  result.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_err  output  1  illegal opcode flag.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE.
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, req_ready=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority after reset.
- Opcodes (result computed bitwise over DATA_W):
  - 0 NOT a (b ignored)
  - 1 AND
  - 2 NAND
  - 3 OR
  - 4 NOR
  - 5 XOR
  - 6 XNOR
  - 7 illegal: result 0, rsp_err=1. For opcodes 0-6, rsp_err=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: capture op, a, b and winner into internal registers; last_grant<=winner; go to EXEC.
  - If no req_valid is high: req_ready=0 and stay in IDLE.
- EXEC:
  - Compute from the captured operands.
  - Register rsp_data, rsp_err and rsp_id; set rsp_valid<=1; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable.
  - On rsp_valid & rsp_ready: rsp_valid<=0 and go to IDLE.
  - A new grant is possible on the cycle after returning to IDLE.
- Latency: handshake in cycle N gives rsp_valid in cycle N+2. Maximum throughput is one operation per 3 cycles.
- req_ready is never asserted outside IDLE; inputs are sampled only at the handshake edge.
- Requester inputs may change freely after their handshake without affecting the response.
- Round-robin wrap: with last_grant=NUM_REQ-1, the scan starts at requester 0.
- A requester whose req_valid stays high is served again only after every other pending requester has been served.
- A single active requester is granted back-to-back, every 3 cycles.
- req_valid dropping while not granted is legal; that request is simply not served.
- Reset mid-operation: immediate return to the reset state. Any in-flight response is discarded and rsp_valid drops asynchronously.
- rsp_ready high in IDLE or EXEC has no effect.

Optional Feature:
- Macro: LOGIC_UNIT_ARBITER_STATS_EN.
- When defined, add output port stat_done_cnt (16 bits):
  - Counts completed responses (rsp_valid & rsp_ready).
  - Saturates at 0xFFFF.
  - Resets to 0.
  - Illegal-opcode responses are counted.
- When not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, single op: requester 0 sends op=1, a=0xF0, b=0x3C with rsp_ready=1.
  - req_ready=0001 in the same cycle.
  - Two cycles later: rsp_valid=1, rsp_data=0x30, rsp_id=0, rsp_err=0.
- All opcodes: a=0xA5, b=0x0F through requester 2.
  - Expected rsp_data by op 0..6: 0x5A, 0x05, 0xFA, 0xAF, 0x50, 0xAA, 0x55.
  - op 7: rsp_data=0x00, rsp_err=1.
- Round-robin fairness: all four req_valid held high with rsp_ready=1.
  - Grant order 0,1,2,3,0,1.
  - A new req_ready every 3 cycles.
  - rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - rsp_valid, rsp_data and rsp_id stay stable; req_ready stays 0000.
  - When rsp_ready=1, the response completes and the next grant is issued one cycle later.
- Reset mid-operation: assert rst in the EXEC state and in the RESP state.
  - Outputs immediately return to reset values.
  - After release, requester 0 has first priority.
- With LOGIC_UNIT_ARBITER_STATS_EN: complete 5 responses, one of them op=7.
  - stat_done_cnt=5.
  - Preload to 0xFFFE and complete 3 responses: stat_done_cnt=0xFFFF.
